fd_pipe_regs: RTL and testbench

FD_PIPE_REGS -- requirements
Module: fd_pipe_regs

---
 rtl/fd_pipe_regs.sv | 140 ++++++++++++++
 tb/tb_fd_pipe_regs.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fd_pipe_regs.sv
// rtl/fd_pipe_regs.sv - fetch/decode pipeline registers with sticky halt.
// Optional performance counters are enabled by defining FD_PERF_CNT_EN.
module fd_pipe_regs #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [1:0]  f_status,
    input  logic [63:0] f_predicted_pc,
    input  logic [63:0] current_pc,
    output logic [63:0] F_predPC,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [63:0] D_pc,
    output logic [1:0]  D_status,
    output logic        halted
`ifdef FD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam logic [1:0] STAT_AOK = 2'd3;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE = 4'hF;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [63:0] r_pred_pc;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic [63:0] r_pc;
    logic [1:0]  r_status;
    logic        r_halted;

    // Once halted, decode only ever receives bubbles until reset.
    logic w_bubble_load;
    assign w_bubble_load = !D_stall && (D_bubble || r_halted);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc <= RESET_PC;
            r_icode   <= ICODE_NOP;
            r_ifun    <= 4'h0;
            r_ra      <= REG_NONE;
            r_rb      <= REG_NONE;
            r_valc    <= 64'd0;
            r_valp    <= 64'd0;
            r_pc      <= 64'd0;
            r_status  <= STAT_AOK;
            r_halted  <= 1'b0;
        end else begin
            if (!F_stall && !r_halted) begin
                r_pred_pc <= f_predicted_pc;
            end
            if (w_bubble_load) begin
                r_icode  <= ICODE_NOP;
                r_ifun   <= 4'h0;
                r_ra     <= REG_NONE;
                r_rb     <= REG_NONE;
                r_valc   <= 64'd0;
                r_valp   <= 64'd0;
                r_pc     <= 64'd0;
                r_status <= STAT_AOK;
            end else if (!D_stall) begin
                r_icode  <= f_icode;
                r_ifun   <= f_ifun;
                r_ra     <= f_rA;
                r_rb     <= f_rB;
                r_valc   <= f_valC;
                r_valp   <= f_valP;
                r_pc     <= current_pc;
                r_status <= f_status;
                if (f_status != STAT_AOK) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    assign F_predPC = r_pred_pc;
    assign D_icode  = r_icode;
    assign D_ifun   = r_ifun;
    assign D_rA     = r_ra;
    assign D_rB     = r_rb;
    assign D_valC   = r_valc;
    assign D_valP   = r_valp;
    assign D_pc     = r_pc;
    assign D_status = r_status;
    assign halted   = r_halted;

`ifdef FD_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (F_stall || D_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble_load) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fd_pipe_regs.sv
// tb/tb_fd_pipe_regs.sv - scoreboard bench for fd_pipe_regs (counter checks need FD_PERF_CNT_EN).
module tb_fd_pipe_regs;

    localparam int CNT_W = 4;

    typedef struct {
        logic [3:0]       icode, ifun, ra, rb;
        logic [63:0]      valc, valp, pc, pred;
        logic [1:0]       status;
        logic             halted;
        logic [CNT_W-1:0] cyc, stl, bub;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, F_stall, D_stall, D_bubble;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP, f_predicted_pc, current_pc;
    logic [1:0]  f_status;
    logic [63:0] F_predPC, D_valC, D_valP, D_pc;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [1:0]  D_status;
    logic        halted;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, bubble_cnt;

    fd_pipe_regs #(.RESET_PC(64'd0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_status(f_status),
        .f_predicted_pc(f_predicted_pc), .current_pc(current_pc),
        .F_predPC(F_predPC), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .D_pc(D_pc), .D_status(D_status), .halted(halted)
`ifdef FD_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

`ifndef FD_PERF_CNT_EN
    assign cycle_cnt  = '0;
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];
    exp_t m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic m_bubble();
        m.icode = 4'h1; m.ifun = 4'h0; m.ra = 4'hF; m.rb = 4'hF;
        m.valc = 64'd0; m.valp = 64'd0; m.pc = 64'd0; m.status = 2'd3;
    endtask

    task automatic step(input logic rs, fs, ds, db,
                        input logic [3:0] ic, ifn, ra, rb,
                        input logic [63:0] vc, vp, input logic [1:0] st,
                        input logic [63:0] pp, cp);
        exp_t e;
        logic old_h;
        rst = rs; F_stall = fs; D_stall = ds; D_bubble = db;
        f_icode = ic; f_ifun = ifn; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_status = st; f_predicted_pc = pp; current_pc = cp;
        if (rs) begin
            m_bubble();
            m.pred = 64'd0; m.halted = 1'b0; m.cyc = '0; m.stl = '0; m.bub = '0;
        end else begin
            old_h = m.halted;
            m.cyc = m.cyc + 1'b1;
            if (fs || ds) m.stl = m.stl + 1'b1;
            if (!fs && !old_h) m.pred = pp;
            if (!ds) begin
                if (db || old_h) begin
                    m_bubble();
                    m.bub = m.bub + 1'b1;
                end else begin
                    m.icode = ic; m.ifun = ifn; m.ra = ra; m.rb = rb;
                    m.valc = vc; m.valp = vp; m.pc = cp; m.status = st;
                    if (st != 2'd3) m.halted = 1'b1;
                end
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("F_predPC", F_predPC, e.pred);
        chk("D_icode", 64'(D_icode), 64'(e.icode));
        chk("D_ifun", 64'(D_ifun), 64'(e.ifun));
        chk("D_rA", 64'(D_rA), 64'(e.ra));
        chk("D_rB", 64'(D_rB), 64'(e.rb));
        chk("D_valC", D_valC, e.valc);
        chk("D_valP", D_valP, e.valp);
        chk("D_pc", D_pc, e.pc);
        chk("D_status", 64'(D_status), 64'(e.status));
        chk("halted", 64'(halted), 64'(e.halted));
`ifdef FD_PERF_CNT_EN
        chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
        chk("stall_cnt", 64'(stall_cnt), 64'(e.stl));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
`endif
    endtask

    initial begin
        rst = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        f_icode = '0; f_ifun = '0; f_rA = '0; f_rB = '0; f_valC = '0; f_valP = '0;
        f_status = 2'd3; f_predicted_pc = '0; current_pc = '0;
        @(posedge clk);
        #1;
        // rst fs ds db  icode ifun rA rB valC valP status predpc curpc
        step(1, 0, 0, 0, 4'h7, 4'h2, 4'h3, 4'h4, 64'h55, 64'h66, 2'd3, 64'h77, 64'h88);
        step(0, 0, 0, 0, 4'h3, 4'h0, 4'hF, 4'h4, 64'h3FF, 64'd10, 2'd3, 64'd10, 64'd0);
        step(0, 1, 1, 0, 4'h6, 4'h1, 4'h2, 4'h3, 64'hAA, 64'd12, 2'd3, 64'd12, 64'd10);
        step(0, 1, 1, 0, 4'h2, 4'h5, 4'h6, 4'h7, 64'hBB, 64'd14, 2'd2, 64'd14, 64'd12);
        step(0, 0, 1, 1, 4'h4, 4'h0, 4'h1, 4'h2, 64'hCC, 64'd20, 2'd3, 64'd20, 64'd10);
        step(0, 0, 0, 1, 4'h5, 4'h0, 4'h1, 4'h2, 64'hDD, 64'd22, 2'd3, 64'd22, 64'd20);
        step(0, 1, 0, 0, 4'h6, 4'h3, 4'h8, 4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd30, 2'd3, 64'd99, 64'd22);
        step(0, 0, 0, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234_5678_9ABC_DEF0, 64'd39, 2'd3, 64'd500, 64'd30);
        step(0, 0, 0, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd501, 2'd0, 64'd501, 64'd500);
        step(0, 0, 0, 0, 4'h3, 4'h0, 4'h1, 4'h2, 64'h11, 64'd510, 2'd3, 64'd510, 64'd501);
        step(0, 0, 0, 0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h22, 64'd520, 2'd3, 64'd520, 64'd510);
        step(0, 0, 1, 0, 4'h5, 4'h0, 4'h1, 4'h2, 64'h33, 64'd530, 2'd3, 64'd530, 64'd520);
        step(0, 0, 0, 0, 4'h6, 4'h0, 4'h1, 4'h2, 64'h44, 64'd540, 2'd3, 64'd540, 64'd530);
        step(1, 1, 1, 1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h44, 64'd540, 2'd3, 64'd540, 64'd530);
        step(0, 0, 0, 0, 4'h5, 4'h2, 4'h3, 4'h4, 64'h77, 64'd600, 2'd1, 64'd600, 64'd590);
        step(0, 0, 0, 0, 4'h3, 4'h0, 4'h1, 4'h2, 64'h88, 64'd610, 2'd3, 64'd610, 64'd600);
        step(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 2'd3, 64'd0, 64'd0);
        for (int i = 0; i < 17; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom}, 2'd3,
                 {$urandom, $urandom}, {$urandom, $urandom});
        end
`ifdef FD_PERF_CNT_EN
        chk("cycle_cnt_wrap", 64'(cycle_cnt), 64'd1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
